// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller: detects load-use hazards, flushes IF/ID on a
//   taken branch, freezes the pipeline while data memory is busy and latches a
//   sticky timeout error if memory stays busy for TIMEOUT consecutive cycles.
//   Also keeps saturating statistics of stall and flush cycles.
//
// Ports
//   clk              clock, rising edge
//   reset            asynchronous reset, active low
//   id_rs, id_rt     source register fields of the instruction in ID
//   id_uses_rt       ID instruction reads rt
//   ex_memRead       instruction in EX is a load
//   ex_wreg          destination register of the instruction in EX
//   ex_branch_taken  branch in EX resolved taken
//   mem_busy         data memory not ready
//   pc_write         PC update enable
//   ifid_write       IF/ID register enable
//   ifid_flush       IF/ID register clear
//   idex_stall       inserts a bubble into ID/EX
//   pipe_hold        freezes ID/EX, EX/MEM and MEM/WB
//   mem_timeout      sticky memory timeout flag
//   stall_cnt        saturating count of cycles with pc_write low
//   flush_cnt        saturating count of cycles with ifid_flush high
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_wreg,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt, wait_inc;
    logic              timeout_nxt;
    logic              load_use;

    // r0 is hardwired to zero, so a load targeting it never creates a hazard
    assign load_use = ex_memRead && (ex_wreg != 5'd0) &&
                      ((ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt)));

    assign wait_inc = wait_cnt + WAIT_W'(1);

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        pipe_hold   = 1'b0;
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        timeout_nxt = mem_timeout;

        if (state == ERR || mem_busy) begin
            // frozen: branch and load-use are ignored
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_stall = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_stall = 1'b1;
        end

        case (state)
            RUN, MWAIT: begin
                if (mem_busy) begin
                    // wait counter holds the number of busy cycles seen so far
                    wait_nxt  = (state == RUN) ? WAIT_W'(1) : wait_inc;
                    state_nxt = MWAIT;
                    if (wait_nxt >= TIMEOUT_V) begin
                        state_nxt   = ERR;
                        timeout_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            end
            default: state_nxt = ERR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (16-bit and 2-bit counters, TIMEOUT=4)
// share the inputs. A cycle model predicts every output; predictions are
// queued when stimulus is applied and popped when outputs are sampled.
module tb_hazard_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_wreg;
    logic        id_uses_rt, ex_memRead, ex_branch_taken, mem_busy;

    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_stall, a_pipe_hold, a_mem_timeout;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_stall, b_pipe_hold, b_mem_timeout;
    logic [1:0]  b_stall_cnt, b_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16), .TIMEOUT(TO)) dut_a (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memRead(ex_memRead), .ex_wreg(ex_wreg), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_write(a_pc_write), .ifid_write(a_ifid_write),
        .ifid_flush(a_ifid_flush), .idex_stall(a_idex_stall), .pipe_hold(a_pipe_hold),
        .mem_timeout(a_mem_timeout), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2), .TIMEOUT(TO)) dut_b (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memRead(ex_memRead), .ex_wreg(ex_wreg), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
        .ifid_flush(b_ifid_flush), .idex_stall(b_idex_stall), .pipe_hold(b_pipe_hold),
        .mem_timeout(b_mem_timeout), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memrd;
        logic [4:0] wreg;
        logic       br;
        logic       busy;
    } stim_t;

    // model: 0 = RUN, 1 = MWAIT, 2 = ERR
    int   m_state, m_wait, sa, fa, sb, fb;
    bit   m_to;
    logic [47:0] sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic stim_t mk(int rs, int rt, bit uses, bit memrd, int wreg, bit br, bit busy);
        stim_t s;
        s.rs = 5'(rs); s.rt = 5'(rt); s.uses_rt = uses; s.memrd = memrd;
        s.wreg = 5'(wreg); s.br = br; s.busy = busy;
        return s;
    endfunction

    function automatic logic [47:0] observed();
        return {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_stall, a_pipe_hold, a_mem_timeout,
                a_stall_cnt, a_flush_cnt,
                b_pc_write, b_ifid_write, b_ifid_flush, b_idex_stall, b_pipe_hold, b_mem_timeout,
                b_stall_cnt, b_flush_cnt};
    endfunction

    task automatic model_reset();
        m_state = 0; m_wait = 0; m_to = 0;
        sa = 0; fa = 0; sb = 0; fb = 0;
    endtask

    // drive one cycle of inputs, queue the predicted outputs, advance the model
    task automatic apply(input stim_t s);
        bit lu, pc, ifw, fl, st, hd;
        id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.uses_rt;
        ex_memRead = s.memrd; ex_wreg = s.wreg; ex_branch_taken = s.br; mem_busy = s.busy;
        lu = s.memrd && s.wreg != 0 && (s.wreg == s.rs || (s.uses_rt && s.wreg == s.rt));
        pc = 1; ifw = 1; fl = 0; st = 0; hd = 0;
        if (m_state == 2 || s.busy) begin
            pc = 0; ifw = 0; hd = 1;
        end else if (s.br) begin
            fl = 1; st = 1;
        end else if (lu) begin
            pc = 0; ifw = 0; st = 1;
        end
        sb_q.push_back({pc, ifw, fl, st, hd, m_to, 16'(sa), 16'(fa),
                        pc, ifw, fl, st, hd, m_to, 2'(sb), 2'(fb)});
        if (reset) begin
            if (!pc) begin
                if (sa < 65535) sa++;
                if (sb < 3) sb++;
            end
            if (fl) begin
                if (fa < 65535) fa++;
                if (fb < 3) fb++;
            end
            if (m_state != 2) begin
                if (s.busy) begin
                    m_wait = (m_state == 0) ? 1 : m_wait + 1;
                    if (m_wait >= TO) begin
                        m_state = 2; m_to = 1;
                    end else begin
                        m_state = 1;
                    end
                end else begin
                    m_state = 0; m_wait = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        stim_t t[2];
        logic [47:0] e, g;
        t[0] = mk(0, 0, 0, 0, 0, 0, 0);
        t[1] = mk(5, 0, 0, 1, 5, 1, 1);
        reset = 1'b0;
        model_reset();
        #1;
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sb_q.pop_front(); g = observed(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", i, g, e);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
    endtask

    task automatic test_load_use();
        stim_t t[7];
        logic [47:0] e, g;
        t[0] = mk(5, 0, 0, 1, 5, 0, 0);
        t[1] = mk(0, 0, 0, 0, 0, 0, 0);
        t[2] = mk(0, 0, 0, 1, 0, 0, 0);
        t[3] = mk(1, 7, 1, 1, 7, 0, 0);
        t[4] = mk(1, 7, 0, 1, 7, 0, 0);
        t[5] = mk(5, 0, 0, 0, 5, 0, 0);
        t[6] = mk(3, 9, 1, 1, 4, 0, 0);
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sb_q.pop_front(); g = observed(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %h expected %h", i, g, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        stim_t t[4];
        logic [47:0] e, g;
        t[0] = mk(5, 0, 0, 1, 5, 1, 0);
        t[1] = mk(0, 0, 0, 0, 0, 0, 0);
        t[2] = mk(0, 0, 0, 0, 0, 1, 0);
        t[3] = mk(0, 0, 0, 0, 0, 0, 0);
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sb_q.pop_front(); g = observed(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL branch[%0d]: got %h expected %h", i, g, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t t[8];
        logic [47:0] e, g;
        t[0] = mk(5, 0, 0, 1, 5, 1, 1);
        t[1] = mk(5, 0, 0, 1, 5, 1, 1);
        t[2] = mk(5, 0, 0, 1, 5, 1, 1);
        t[3] = mk(5, 0, 0, 1, 5, 0, 0);
        t[4] = mk(0, 0, 0, 0, 0, 0, 0);
        t[5] = mk(0, 0, 0, 0, 0, 0, 1);
        t[6] = mk(0, 0, 0, 0, 0, 1, 0);
        t[7] = mk(0, 0, 0, 0, 0, 0, 0);
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sb_q.pop_front(); g = observed(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL mem_wait[%0d]: got %h expected %h", i, g, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        logic [47:0] e, g;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(i < 5 ? mk(5, 0, 0, 1, 5, 0, 0) : mk(0, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            e = sb_q.pop_front(); g = observed(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got %h expected %h", i, g, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [47:0] e, g;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(i < 6 ? mk(0, 0, 0, 0, 0, 0, 1) : mk(5, 0, 0, 1, 5, i[0], 0));
            @(negedge clk);
            e = sb_q.pop_front(); g = observed(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL timeout[%0d]: got %h expected %h", i, g, e);
            end
            @(posedge clk); #1;
        end
        // reset asserted mid-cycle from ERR must take effect without a clock edge
        #2;
        reset = 1'b0;
        model_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0));
        #1;
        e = sb_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", g, e);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [47:0] e, g;
        stim_t s;
        for (int i = 0; i < 150; i++) begin
            if (i % 50 == 49) do_reset();
            s = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            apply(s);
            @(negedge clk);
            e = sb_q.pop_front(); g = observed(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, g, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        id_rs = '0; id_rt = '0; ex_wreg = '0;
        id_uses_rt = 1'b0; ex_memRead = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_saturation();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum consecutive mem_busy cycles tolerated.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low forces the reset state immediately.
REQ-005 id_rs  input  5  rs field of the instruction in ID.
REQ-006 id_rt  input  5  rt field of the instruction in ID.
REQ-007 id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-008 ex_memRead  input  1  memRead of the instruction in EX (ID/EX register output).
REQ-009 ex_wreg  input  5  destination register of the instruction in EX.
REQ-010 ex_branch_taken  input  1  branch in EX resolved taken this cycle.
REQ-011 mem_busy  input  1  data memory not ready this cycle.
REQ-012 pc_write  output  1  PC update enable.
REQ-013 ifid_write  output  1  IF/ID register enable.
REQ-014 ifid_flush  output  1  IF/ID register clear.
REQ-015 idex_stall  output  1  drives the ID/EX stall (bubble) input.
REQ-016 pipe_hold  output  1  freezes ID/EX, EX/MEM and MEM/WB.
REQ-017 mem_timeout  output  1  sticky error flag.
REQ-018 stall_cnt  output  CNT_W  saturating count of cycles with pc_write=0.
REQ-019 flush_cnt  output  CNT_W  saturating count of cycles with ifid_flush=1.

Function
REQ-020 SHALL implement FSM states RUN, MWAIT, ERR; the control outputs (REQ-012..016) SHALL be combinational from the state and the current inputs.
REQ-021 load_use SHALL be 1 when ex_memRead=1, ex_wreg!=0, and either ex_wreg==id_rs or (id_uses_rt=1 and ex_wreg==id_rt).
REQ-022 RUN, mem_busy=1: pc_write=0, ifid_write=0, pipe_hold=1, idex_stall=0, ifid_flush=0; wait counter loads 1; next state MWAIT.
REQ-023 RUN, mem_busy=0, ex_branch_taken=1: ifid_flush=1, idex_stall=1, pc_write=1, ifid_write=1, pipe_hold=0; stay in RUN; branch SHALL take priority over load_use.
REQ-024 RUN, mem_busy=0, ex_branch_taken=0, load_use=1: pc_write=0, ifid_write=0, idex_stall=1, ifid_flush=0, pipe_hold=0; stay in RUN; exactly one bubble per load-use pair.
REQ-025 RUN with no condition active: pc_write=1, ifid_write=1, all other control outputs 0.
REQ-026 MWAIT, mem_busy=1: outputs as in REQ-022; wait counter increments; when the counter reaches TIMEOUT with mem_busy still 1, next state SHALL be ERR and mem_timeout SHALL be set.
REQ-027 MWAIT, mem_busy=0: outputs evaluated exactly as in RUN with mem_busy=0 (REQ-023..025); next state RUN; wait counter clears.
REQ-028 ex_branch_taken and load_use SHALL be ignored while mem_busy=1 and in ERR.
REQ-029 ERR: pc_write=0, ifid_write=0, pipe_hold=1, idex_stall=0, ifid_flush=0; remain in ERR until reset.
REQ-030 stall_cnt SHALL increment at the clock edge following any cycle with pc_write=0 and saturate at 2^CNT_W-1.
REQ-031 flush_cnt SHALL increment at the clock edge following any cycle with ifid_flush=1 and saturate at 2^CNT_W-1.
REQ-032 The wait counter SHALL be wide enough to hold TIMEOUT.

Reset
REQ-033 With reset low: state=RUN, wait counter=0, mem_timeout=0, stall_cnt=0, flush_cnt=0; control outputs follow RUN evaluation.
REQ-034 Reset asserted in MWAIT or ERR SHALL return the FSM to RUN without waiting for a clock edge.

Verification
REQ-035 ex_memRead=1, ex_wreg=5, id_rs=5, one cycle -> pc_write=0, ifid_write=0, idex_stall=1; stall_cnt 0->1.
REQ-036 Same load_use plus ex_branch_taken=1 -> ifid_flush=1, idex_stall=1, pc_write=1; flush_cnt +1, stall_cnt unchanged.
REQ-037 ex_wreg=0 with ex_memRead=1, id_rs=0 -> no stall; pc_write=1.
REQ-038 mem_busy high for 3 cycles, then low -> pipe_hold=1 for 3 cycles, state RUN afterwards, stall_cnt +3, mem_timeout=0.
REQ-039 TIMEOUT=4, mem_busy held high -> mem_timeout=1 after the 4th busy cycle, outputs frozen; pulse reset low -> mem_timeout=0, counters 0, pc_write=1.
REQ-040 CNT_W=2, 5 consecutive load-use stall cycles -> stall_cnt saturates at 3.
